bht_counter_array: RTL and testbench

- Branch history table storage that sits downstream of the branch unit's BHT write interface and upstream of fetch-stage prediction.
- Holds 512 sets x 4 two-bit saturating counters, one counter per 4-byte instruction slot, plus one valid bit per set.
- Registered read port for fetch. Single-cycle read-modify-write update port driven by the branch unit scoreboard.
- Built-in init/flush sweep FSM.

---
 rtl/bht_counter_array.sv | 160 ++++++++++++++++
 tb/tb_bht_counter_array.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bht_counter_array.sv
// Branch history table storage: 2**BHTBTB_INDEX_WIDTH sets of four 2-bit
// saturating counters plus a per-set valid bit, with an init/flush sweep.
//
// Ports:
//   clock, reset_n                  clock and asynchronous active-low reset
//   flush                           synchronous pulse, restarts the init sweep
//   rd_req, rd_index                fetch read request and set index
//   bjusb_bht_write_*               branch unit update port (enable, index,
//                                   counter select, inc, dec)
//   bjusb_bht_valid_in              write qualifier
//   rd_data_valid                   read response valid (1 cycle after rd_req)
//   rd_counters                     {c3,c2,c1,c0} of the read set
//   rd_set_valid                    valid bit of the read set
//   rd_taken_mask                   per-slot predict-taken
//   ready                           table is in normal operation
module bht_counter_array #(
  parameter int unsigned BHTBTB_INDEX_WIDTH = 9,
  parameter logic [1:0]  CNT_INIT           = 2'b01
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          rd_req,
  input  logic [BHTBTB_INDEX_WIDTH-1:0] rd_index,
  input  logic                          bjusb_bht_write_enable,
  input  logic [BHTBTB_INDEX_WIDTH-1:0] bjusb_bht_write_index,
  input  logic [1:0]                    bjusb_bht_write_counter_select,
  input  logic                          bjusb_bht_write_inc,
  input  logic                          bjusb_bht_write_dec,
  input  logic                          bjusb_bht_valid_in,
  output logic                          rd_data_valid,
  output logic [7:0]                    rd_counters,
  output logic                          rd_set_valid,
  output logic [3:0]                    rd_taken_mask,
  output logic                          ready
);

  localparam int unsigned IDX_W    = BHTBTB_INDEX_WIDTH;
  localparam int unsigned NUM_SETS = 1 << IDX_W;
  localparam logic [7:0]  INIT_SET = {4{CNT_INIT}};

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   init_idx_q, init_idx_d;
  logic [7:0]         cnt_mem [NUM_SETS];
  logic [NUM_SETS-1:0] set_valid_q;

  logic               wr_acc;
  logic [7:0]         wr_base;
  logic [7:0]         wr_set;
  logic [2:0]         wr_bit;
  logic [1:0]         wr_old;
  logic [1:0]         wr_new;
  logic               rd_hit;
  logic [7:0]         rd_cnt_sel;
  logic               rd_v_sel;

  // State register and sweep index
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      ready      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ready      <= (state_d == ST_READY);
    end
  end

  // Next-state logic: sweep all sets, flush restarts from index 0
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (flush) begin
      state_d    = ST_INIT;
      init_idx_d = '0;
    end else if (state_q == ST_INIT) begin
      init_idx_d = init_idx_q + IDX_W'(1);
      if (init_idx_q == IDX_W'(NUM_SETS - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  assign wr_acc = bjusb_bht_write_enable & bjusb_bht_valid_in &
                  (state_q == ST_READY) & ~flush;

  // Post-write set value; an invalid set restarts from CNT_INIT
  always_comb begin
    wr_base = set_valid_q[bjusb_bht_write_index] ? cnt_mem[bjusb_bht_write_index]
                                                 : INIT_SET;
    wr_bit  = {bjusb_bht_write_counter_select, 1'b0};
    wr_old  = wr_base[wr_bit +: 2];
    wr_new  = wr_old;
    if (bjusb_bht_write_inc && !bjusb_bht_write_dec && wr_old != 2'b11) begin
      wr_new = wr_old + 2'd1;
    end else if (bjusb_bht_write_dec && !bjusb_bht_write_inc && wr_old != 2'b00) begin
      wr_new = wr_old - 2'd1;
    end
    wr_set = wr_base;
    wr_set[wr_bit +: 2] = wr_new;
  end

  // Counter storage (no reset: every set is rewritten by the sweep)
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      cnt_mem[init_idx_q] <= INIT_SET;
    end else if (wr_acc) begin
      cnt_mem[bjusb_bht_write_index] <= wr_set;
    end
  end

  // Valid bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      set_valid_q <= '0;
    end else if (state_q == ST_INIT) begin
      set_valid_q[init_idx_q] <= 1'b0;
    end else if (wr_acc) begin
      set_valid_q[bjusb_bht_write_index] <= 1'b1;
    end
  end

  // Read source with same-index write bypass
  always_comb begin
    rd_hit     = wr_acc && (rd_index == bjusb_bht_write_index);
    rd_cnt_sel = rd_hit ? wr_set : cnt_mem[rd_index];
    rd_v_sel   = rd_hit | set_valid_q[rd_index];
  end

  // Registered read response; holds when no request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_valid <= 1'b0;
      rd_counters   <= '0;
      rd_set_valid  <= 1'b0;
      rd_taken_mask <= '0;
    end else begin
      rd_data_valid <= rd_req;
      if (rd_req) begin
        if (state_q != ST_READY || flush) begin
          rd_counters   <= '0;
          rd_set_valid  <= 1'b0;
          rd_taken_mask <= '0;
        end else begin
          rd_counters   <= rd_cnt_sel;
          rd_set_valid  <= rd_v_sel;
          rd_taken_mask <= {rd_cnt_sel[7], rd_cnt_sel[5], rd_cnt_sel[3], rd_cnt_sel[1]}
                           & {4{rd_v_sel}};
        end
      end
    end
  end

endmodule

// File: tb/tb_bht_counter_array.sv
// Directed self-checking bench for bht_counter_array.
module tb_bht_counter_array;

  localparam int unsigned W = 9;

  logic         clock;
  logic         reset_n;
  logic         flush;
  logic         rd_req;
  logic [W-1:0] rd_index;
  logic         we;
  logic [W-1:0] widx;
  logic [1:0]   wsel;
  logic         winc;
  logic         wdec;
  logic         wvalid;
  logic         rd_data_valid;
  logic [7:0]   rd_counters;
  logic         rd_set_valid;
  logic [3:0]   rd_taken_mask;
  logic         ready;

  int checks;
  int errors;

  bht_counter_array #(.BHTBTB_INDEX_WIDTH(W), .CNT_INIT(2'b01)) dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .flush                          (flush),
    .rd_req                         (rd_req),
    .rd_index                       (rd_index),
    .bjusb_bht_write_enable         (we),
    .bjusb_bht_write_index          (widx),
    .bjusb_bht_write_counter_select (wsel),
    .bjusb_bht_write_inc            (winc),
    .bjusb_bht_write_dec            (wdec),
    .bjusb_bht_valid_in             (wvalid),
    .rd_data_valid                  (rd_data_valid),
    .rd_counters                    (rd_counters),
    .rd_set_valid                   (rd_set_valid),
    .rd_taken_mask                  (rd_taken_mask),
    .ready                          (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_wr();
    we = 1'b0; winc = 1'b0; wdec = 1'b0; wvalid = 1'b0; widx = '0; wsel = '0;
  endtask

  task automatic wr(input int idx, input int sel, input logic inc, input logic dec,
                    input logic vin);
    we = 1'b1; widx = W'(idx); wsel = 2'(sel); winc = inc; wdec = dec; wvalid = vin;
    tick();
    clr_wr();
  endtask

  task automatic rd(input int idx);
    rd_req = 1'b1; rd_index = W'(idx);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] cnt, input logic v,
                        input logic [3:0] mask);
    check({tag, "_dv"},   32'(rd_data_valid), 32'd1);
    check({tag, "_cnt"},  32'(rd_counters),   32'(cnt));
    check({tag, "_sv"},   32'(rd_set_valid),  32'(v));
    check({tag, "_mask"}, 32'(rd_taken_mask), 32'(mask));
  endtask

  // Count cycles until ready; optionally inject a write at cycle 100
  task automatic wait_ready(input string tag, input logic inject, output int n,
                            output logic bad_rd);
    n = 0;
    bad_rd = 1'b0;
    while (!ready && n < 600) begin
      if (inject && n == 100) begin
        we = 1'b1; widx = W'(0); wsel = 2'd0; winc = 1'b1; wvalid = 1'b1;
      end
      tick();
      clr_wr();
      n++;
      if (rd_req && (rd_data_valid !== 1'b1 || rd_set_valid !== 1'b0 ||
                     rd_taken_mask !== 4'b0 || (rd_counters !== 8'h0 && !ready)))
        bad_rd = 1'b1;
    end
    check(tag, 32'(n), 32'd512);
  endtask

  int   n;
  logic bad;

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; flush = 1'b0; rd_req = 1'b0; rd_index = '0;
    clr_wr();
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_dv",    32'(rd_data_valid), 32'd0);
    check("rst_cnt",   32'(rd_counters), 32'd0);

    // Initial sweep with reads every cycle
    reset_n = 1'b1; rd_req = 1'b1; rd_index = W'(5);
    wait_ready("init_len", 1'b0, n, bad);
    check("init_reads", 32'(bad), 32'd0);
    rd_req = 1'b0;

    // First write to invalid set: CNT_INIT then inc on counter 2
    wr(5, 2, 1'b1, 1'b0, 1'b1);
    rd(5); chk_rd("w5_inc1", 8'h65, 1'b1, 4'b0100);

    // Back-to-back incs saturate at 11
    wr(5, 2, 1'b1, 1'b0, 1'b1);
    wr(5, 2, 1'b1, 1'b0, 1'b1);
    wr(5, 2, 1'b1, 1'b0, 1'b1);
    rd(5); chk_rd("w5_sat", 8'h75, 1'b1, 4'b0100);

    wr(5, 2, 1'b0, 1'b1, 1'b1); rd(5); chk_rd("w5_dec1", 8'h65, 1'b1, 4'b0100);
    wr(5, 2, 1'b0, 1'b1, 1'b1); rd(5); chk_rd("w5_dec2", 8'h55, 1'b1, 4'b0000);
    wr(5, 2, 1'b0, 1'b1, 1'b1); rd(5); chk_rd("w5_dec3", 8'h45, 1'b1, 4'b0000);
    wr(5, 2, 1'b0, 1'b1, 1'b1); rd(5); chk_rd("w5_dec4", 8'h45, 1'b1, 4'b0000);

    // Same-cycle read/write to idx 9 (bypass)
    rd_req = 1'b1; rd_index = W'(9);
    wr(9, 0, 1'b1, 1'b0, 1'b1);
    rd_req = 1'b0;
    chk_rd("byp9", 8'h56, 1'b1, 4'b0001);

    // inc & dec together hold
    wr(9, 0, 1'b1, 1'b1, 1'b1);
    rd(9); chk_rd("hold9", 8'h56, 1'b1, 4'b0001);

    // valid_in=0 drops the write
    wr(9, 0, 1'b1, 1'b0, 1'b0);
    rd(9); chk_rd("novin9", 8'h56, 1'b1, 4'b0001);

    // Different indices in the same cycle are independent
    rd_req = 1'b1; rd_index = W'(5);
    wr(9, 1, 1'b1, 1'b0, 1'b1);
    rd_req = 1'b0;
    chk_rd("indep5", 8'h45, 1'b1, 4'b0000);
    rd(9); chk_rd("indep9", 8'h5A, 1'b1, 4'b0011);

    // No request: valid drops, data holds
    tick();
    check("hold_dv",  32'(rd_data_valid), 32'd0);
    check("hold_cnt", 32'(rd_counters),   32'h5A);

    // Flush with same-cycle write and read at idx 5
    flush = 1'b1; rd_req = 1'b1; rd_index = W'(5);
    wr(5, 0, 1'b1, 1'b0, 1'b1);
    flush = 1'b0; rd_req = 1'b0;
    chk_rd("flush_rd", 8'h00, 1'b0, 4'b0000);
    check("flush_ready", 32'(ready), 32'd0);
    wait_ready("flush_len", 1'b1, n, bad);
    rd(5); chk_rd("post_flush5", 8'h55, 1'b0, 4'b0000);
    rd(0); chk_rd("init_wr_drop0", 8'h55, 1'b0, 4'b0000);

    // Async reset mid-sweep
    wr(7, 3, 1'b1, 1'b0, 1'b1);
    rd(7); chk_rd("w7", 8'h95, 1'b1, 4'b1000);
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (199) tick();
    rd_req = 1'b1; rd_index = W'(7);
    #2 reset_n = 1'b0;
    #1;
    check("async_ready", 32'(ready), 32'd0);
    check("async_dv",    32'(rd_data_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    wait_ready("reset_len", 1'b0, n, bad);
    check("reset_reads", 32'(bad), 32'd0);
    rd_req = 1'b0;
    rd(7); chk_rd("post_rst7", 8'h55, 1'b0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
